// File: rtl/alu_dispatch_if.sv
// Command, ALU-side and response signals of alu_dispatch bundled as one interface.
// slave = the dispatcher; master = its environment (command source, ALU, response sink).
interface alu_dispatch_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_opcode;
  logic [15:0]      cmd_opA;
  logic [15:0]      cmd_opB;
  logic [TAG_W-1:0] cmd_tag;

  logic             alu_en;
  logic [15:0]      alu_opA;
  logic [15:0]      alu_opB;
  logic [1:0]       alu_opcode;
  logic             alu_done;
  logic [31:0]      alu_res;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_res;
  logic [1:0]       rsp_opcode;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_opcode, cmd_opA, cmd_opB, cmd_tag,
    output alu_done, alu_res, rsp_ready,
    input  cmd_ready, alu_en, alu_opA, alu_opB, alu_opcode,
    input  rsp_valid, rsp_res, rsp_opcode, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_opA, cmd_opB, cmd_tag,
    input  alu_done, alu_res, rsp_ready,
    output cmd_ready, alu_en, alu_opA, alu_opB, alu_opcode,
    output rsp_valid, rsp_res, rsp_opcode, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_dispatch.sv
// FIFO-buffered dispatcher for a sequential ALU: one op in flight, alu_en >= 2 cycles after accept, registered response.
// Holds rsp_* while rsp_ready=0 and issues nothing meanwhile; ALU_DISPATCH_TIMEOUT_EN adds a TIMEOUT-cycle done watchdog.
module alu_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     nrst,
  alu_dispatch_if.slave            bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("alu_dispatch: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef struct packed {
    logic [1:0]       opcode;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t           state;
  cmd_t             mem [DEPTH];
  cmd_t             wr_entry;
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  logic             alu_en_q;
  logic [15:0]      alu_op_a_q;
  logic [15:0]      alu_op_b_q;
  logic [1:0]       alu_opcode_q;
  logic [TAG_W-1:0] tag_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_res_q;
  logic [1:0]       rsp_opcode_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // cmd_ready depends only on the registered count, so a same-cycle pop never frees a slot.
  assign bus.cmd_ready = (count != (AW + 1)'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == ISSUE);
  assign wr_entry      = '{opcode: bus.cmd_opcode, op_a: bus.cmd_opA,
                           op_b: bus.cmd_opB, tag: bus.cmd_tag};
  assign head          = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;
  logic          rsp_err_q;
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      alu_en_q     <= 1'b0;
      alu_op_a_q   <= '0;
      alu_op_b_q   <= '0;
      alu_opcode_q <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_res_q    <= '0;
      rsp_opcode_q <= '0;
      rsp_tag_q    <= '0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      timer        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      alu_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            alu_op_a_q   <= head.op_a;
            alu_op_b_q   <= head.op_b;
            alu_opcode_q <= head.opcode;
            tag_q        <= head.tag;
            alu_en_q     <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef ALU_DISPATCH_TIMEOUT_EN
          timer <= '0;
`endif
        end
        WAIT: begin
          if (bus.alu_done) begin
            rsp_res_q    <= bus.alu_res;
            rsp_opcode_q <= alu_opcode_q;
            rsp_tag_q    <= tag_q;
            rsp_valid_q  <= 1'b1;
            state        <= HOLD;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_res_q    <= '0;
            rsp_opcode_q <= alu_opcode_q;
            rsp_tag_q    <= tag_q;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state        <= HOLD;
          end else begin
            timer <= timer + 1'b1;
`endif
          end
        end
        HOLD: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_en     = alu_en_q;
  assign bus.alu_opA    = alu_op_a_q;
  assign bus.alu_opB    = alu_op_b_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_res    = rsp_res_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign busy           = (state != IDLE);
  assign fifo_count     = count;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with an ALU stub whose done latency is programmable (0 = never).
// Build with +define+ALU_DISPATCH_TIMEOUT_EN to exercise the watchdog branch.
module tb_alu_dispatch;

  logic       clk = 1'b0;
  logic       nrst;
  logic       busy;
  logic [2:0] fifo_count;

  int n_vec = 0;
  int n_bad = 0;
  int stub_lat = 1;
  int stub_cnt = 0;
  int en_cnt = 0;

  alu_dispatch_if #(.TAG_W(4)) bus ();

  alu_dispatch #(.DEPTH(4), .TAG_W(4), .TIMEOUT(64)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .bus        (bus),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // ALU stub: samples en on the falling edge, raises done for one cycle stub_lat cycles later.
  always @(negedge clk) begin
    if (nrst !== 1'b1) begin
      stub_cnt     = 0;
      bus.alu_done = 1'b0;
      bus.alu_res  = 32'h0;
    end else if (bus.alu_en === 1'b1) begin
      en_cnt++;
      stub_cnt     = stub_lat;
      bus.alu_done = 1'b0;
      case (bus.alu_opcode)
        2'b00:   bus.alu_res = $signed(bus.alu_opA) + $signed(bus.alu_opB);
        2'b01:   bus.alu_res = $signed(bus.alu_opA) * $signed(bus.alu_opB);
        default: bus.alu_res = {16'h0, bus.alu_opA};
      endcase
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      bus.alu_done = (stub_cnt == 0);
    end else begin
      bus.alu_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] t);
    bus.cmd_opcode = op;
    bus.cmd_opA    = a;
    bus.cmd_opB    = b;
    bus.cmd_tag    = t;
    bus.cmd_valid  = 1'b1;
    step();
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.rsp_valid), 32'd1);
  endtask

  logic [31:0] exp_res [4] = '{32'd14985, 32'hFFFF_FFEB, 32'd90000, 32'd40000};
  int en0;
  bit ok;

  initial begin
    nrst          = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = 2'b00;
    bus.cmd_opA   = 16'h0;
    bus.cmd_opB   = 16'h0;
    bus.cmd_tag   = 4'h0;
    bus.rsp_ready = 1'b0;

    // reset values
    step();
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst alu_en", 32'(bus.alu_en), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst fifo_count", 32'(fifo_count), 32'd0);
    chk("rst rsp_res", bus.rsp_res, 32'd0);
    chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    step();
    nrst = 1'b1;

    // add 111+135 tag 3, latency 1, response left pending
    stub_lat = 1;
    en0 = en_cnt;
    push(2'b00, 16'd111, 16'd135, 4'd3);
    bus.cmd_valid = 1'b0;
    chk("add en at accept", 32'(bus.alu_en), 32'd0);
    step();
    chk("add en k+1", 32'(bus.alu_en), 32'd1);
    chk("add count before pop", 32'(fifo_count), 32'd1);
    chk("add busy", 32'(busy), 32'd1);
    step();
    chk("add en pulse end", 32'(bus.alu_en), 32'd0);
    chk("add count after pop", 32'(fifo_count), 32'd0);
    chk("add alu_opA", 32'(bus.alu_opA), 32'd111);
    chk("add rsp not yet", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("add rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("add rsp_res", bus.rsp_res, 32'd246);
    chk("add rsp_tag", 32'(bus.rsp_tag), 32'd3);
    chk("add rsp_opcode", 32'(bus.rsp_opcode), 32'd0);
    chk("add en count", 32'(en_cnt - en0), 32'd1);

    // four mults queued behind the held response, 20 cycles of backpressure
    ok = 1'b1;
    en0 = en_cnt;
    push(2'b01, 16'd135, 16'd111, 4'd4);
    push(2'b01, 16'hFFFD, 16'd7, 4'd5);
    push(2'b01, 16'd300, 16'd300, 4'd6);
    push(2'b01, 16'hFF38, 16'hFF38, 4'd7);
    bus.cmd_valid = 1'b0;
    chk("full count", 32'(fifo_count), 32'd4);
    chk("full cmd_ready", 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 32'd246 || bus.rsp_tag !== 4'd3)
        ok = 1'b0;
      step();
    end
    chk("hold rsp stable", 32'(ok), 32'd1);
    chk("hold no alu_en", 32'(en_cnt - en0), 32'd0);
    stub_lat = 17;
    bus.rsp_ready = 1'b1;
    step();
    chk("release rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("release idle busy", 32'(busy), 32'd0);
    chk("release idle en", 32'(bus.alu_en), 32'd0);
    step();
    chk("release en", 32'(bus.alu_en), 32'd1);
    chk("release count 4", 32'(fifo_count), 32'd4);
    step();
    chk("issue count 3", 32'(fifo_count), 32'd3);
    chk("issue cmd_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_rsp("mult rsp_valid");
      chk("mult rsp_res", bus.rsp_res, exp_res[i]);
      chk("mult rsp_tag", 32'(bus.rsp_tag), 32'(4 + i));
      chk("mult rsp_opcode", 32'(bus.rsp_opcode), 32'd1);
      step();
    end
    chk("mult drained", 32'(fifo_count), 32'd0);

    // reset during WAIT with two commands queued
    stub_lat = 0;
    push(2'b00, 16'd1, 16'd2, 4'd11);
    push(2'b00, 16'd3, 16'd4, 4'd12);
    push(2'b00, 16'd5, 16'd6, 4'd13);
    bus.cmd_valid = 1'b0;
    step();
    step();
    chk("pre-rst busy", 32'(busy), 32'd1);
    chk("pre-rst count", 32'(fifo_count), 32'd2);
    chk("pre-rst alu_opA", 32'(bus.alu_opA), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst count", 32'(fifo_count), 32'd0);
    chk("async rst alu_opA", 32'(bus.alu_opA), 32'd0);
    chk("async rst rsp_tag", 32'(bus.rsp_tag), 32'd0);
    chk("async rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    nrst = 1'b1;
    stub_lat = 1;
    en0 = en_cnt;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.rsp_valid !== 1'b0) ok = 1'b0;
    end
    chk("post-rst no rsp", 32'(ok), 32'd1);
    chk("post-rst no en", 32'(en_cnt - en0), 32'd0);
    chk("post-rst count", 32'(fifo_count), 32'd0);

    // recovery: signed add -5+2, held for the timeout step
    bus.rsp_ready = 1'b0;
    push(2'b00, 16'hFFFB, 16'd2, 4'd10);
    bus.cmd_valid = 1'b0;
    wait_rsp("neg add rsp_valid");
    chk("neg add rsp_res", bus.rsp_res, 32'hFFFF_FFFD);
    chk("neg add rsp_tag", 32'(bus.rsp_tag), 32'd10);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // ALU never completes
    stub_lat = 0;
    push(2'b01, 16'd7, 16'd9, 4'd9);
    bus.cmd_valid = 1'b0;
    repeat (65) step();
    chk("to 63 rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("to 63 busy", 32'(busy), 32'd1);
    step();
`ifdef ALU_DISPATCH_TIMEOUT_EN
    chk("to rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("to rsp_res", bus.rsp_res, 32'd0);
    chk("to rsp_tag", 32'(bus.rsp_tag), 32'd9);
    bus.rsp_ready = 1'b1;
    step();
    chk("to drained", 32'(bus.rsp_valid), 32'd0);
`else
    repeat (40) step();
    chk("no-to rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("no-to busy", 32'(busy), 32'd1);
    chk("no-to rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("no-to rsp_res held", bus.rsp_res, 32'hFFFF_FFFD);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
